// File: rtl/charlie_pkg.sv
// Shared constants and index helpers for the charlieplex scan controller.
// Index layout: [5:3] is the row line, [2:0] is the column line.
package charlie_pkg;

    localparam int N_LINES = 8;
    localparam int N_LEDS  = 64;
    localparam int IDX_W   = 6;
    localparam int LINE_W  = $clog2(N_LINES);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    function automatic logic [LINE_W-1:0] row_of(input logic [IDX_W-1:0] idx);
        return idx[IDX_W-1:LINE_W];
    endfunction

    function automatic logic [LINE_W-1:0] col_of(input logic [IDX_W-1:0] idx);
        return idx[LINE_W-1:0];
    endfunction

    function automatic logic is_diag(input logic [IDX_W-1:0] idx);
        return row_of(idx) == col_of(idx);
    endfunction

    // A line cannot drive itself, so diagonal positions never light.
    function automatic logic [N_LEDS-1:0] elig_mask(input logic [N_LEDS-1:0] leds,
                                                    input logic              skip_off);
        logic [N_LEDS-1:0] m;
        for (int i = 0; i < N_LEDS; i++) begin
            m[i] = !is_diag(IDX_W'(i)) && (!skip_off || leds[i]);
        end
        return m;
    endfunction

endpackage

// File: rtl/charlie_next_idx.sv
// Combinational search for the next eligible LED index above the current one,
// wrapping mod 64, plus the lowest eligible index of the mask.
module charlie_next_idx
    import charlie_pkg::*;
(
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [N_LEDS-1:0] mask,
    output logic [IDX_W-1:0]  next_idx,
    output logic              wrap,
    output logic              none_elig,
    output logic [IDX_W-1:0]  first_idx
);

    logic [IDX_W-1:0] above_idx;
    logic             found_above;

    // Walk downward so the final hit is the lowest qualifying position.
    always_comb begin
        first_idx   = '0;
        above_idx   = '0;
        found_above = 1'b0;
        for (int i = N_LEDS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = IDX_W'(i);
                if (i > int'(cur_idx)) begin
                    above_idx   = IDX_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    assign none_elig = ~|mask;
    assign wrap      = ~found_above;
    assign next_idx  = found_above ? above_idx : first_idx;

endmodule

// File: rtl/charlie_scan_ctrl.sv
// Scan controller with double-buffered 64-bit frame store for the charlieplex
// driver; buffer swaps only land on frame boundaries to avoid tearing.
module charlie_scan_ctrl
    import charlie_pkg::*;
#(
    parameter  int DWELL_CYCLES = 16,
    localparam int DWELL_W      = $clog2(DWELL_CYCLES + 1)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              skip_off,
    input  logic              wr_en,
    input  logic [2:0]        wr_row,
    input  logic [7:0]        wr_data,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              frame_done,
    output logic [IDX_W-1:0]  charlie_index,
    output logic [N_LEDS-1:0] frame_out
);

    scan_state_t        state, state_d;
    logic [N_LEDS-1:0]  front, back, front_d, back_d, frame_d;
    logic [IDX_W-1:0]   idx_d;
    logic [DWELL_W-1:0] dwell_cnt, cnt_d;
    logic               pend_d, sdone_d, fdone_d;

    logic [N_LEDS-1:0]  front_elig, back_elig;
    logic [IDX_W-1:0]   next_f, first_f, next_b, first_b;
    logic               wrap_f, none_f, wrap_b, none_b;
    logic               dwell_tc, boundary, apply_swap;
    logic [N_LEDS-1:0]  new_front;
    logic               new_none;
    logic [IDX_W-1:0]   new_first;
    logic               unused_back;

    assign front_elig = elig_mask(front, skip_off);
    assign back_elig  = elig_mask(back, skip_off);

    charlie_next_idx u_front_search (
        .cur_idx   (charlie_index),
        .mask      (front_elig),
        .next_idx  (next_f),
        .wrap      (wrap_f),
        .none_elig (none_f),
        .first_idx (first_f)
    );

    // The back-buffer search only supplies the first LED of a freshly swapped frame.
    charlie_next_idx u_back_search (
        .cur_idx   (charlie_index),
        .mask      (back_elig),
        .next_idx  (next_b),
        .wrap      (wrap_b),
        .none_elig (none_b),
        .first_idx (first_b)
    );

    assign unused_back = ^{wrap_b, next_b};

    assign dwell_tc   = dwell_cnt == DWELL_W'(DWELL_CYCLES - 1);
    assign boundary   = (state == ST_SCAN) && enable && dwell_tc && (wrap_f || none_f);
    assign apply_swap = swap_pending && ((state == ST_IDLE) || boundary);
    assign new_front  = apply_swap ? back    : front;
    assign new_none   = apply_swap ? none_b  : none_f;
    assign new_first  = apply_swap ? first_b : first_f;

    always_comb begin
        state_d = state;
        idx_d   = charlie_index;
        cnt_d   = dwell_cnt;
        frame_d = frame_out;
        front_d = new_front;
        back_d  = back;
        pend_d  = swap_pending;
        sdone_d = apply_swap;
        fdone_d = 1'b0;

        if (wr_en) begin
            back_d[{wr_row, 3'b000} +: 8] = wr_data;
        end
        if (swap_req) begin
            pend_d = 1'b1;
        end
        if (apply_swap) begin
            pend_d = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                idx_d   = '0;
                cnt_d   = '0;
                frame_d = '0;
                if (enable) begin
                    state_d = ST_SCAN;
                    idx_d   = new_none ? '0 : new_first;
                    frame_d = new_none ? '0 : new_front;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    frame_d = '0;
                end else begin
                    frame_d = new_none ? '0 : new_front;
                    if (dwell_tc) begin
                        cnt_d   = '0;
                        fdone_d = boundary;
                        if (new_none) begin
                            idx_d = '0;
                        end else if (apply_swap) begin
                            idx_d = new_first;
                        end else begin
                            idx_d = next_f;
                        end
                    end else begin
                        cnt_d = dwell_cnt + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            front         <= '0;
            back          <= '0;
            charlie_index <= '0;
            dwell_cnt     <= '0;
            frame_out     <= '0;
            swap_pending  <= 1'b0;
            swap_done     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_d;
            front         <= front_d;
            back          <= back_d;
            charlie_index <= idx_d;
            dwell_cnt     <= cnt_d;
            frame_out     <= frame_d;
            swap_pending  <= pend_d;
            swap_done     <= sdone_d;
            frame_done    <= fdone_d;
        end
    end

endmodule

// File: tb/tb_charlie_scan_ctrl.sv
// Self-checking bench for charlie_scan_ctrl: directed table and sequences plus
// randomized traffic compared against a behavioural frame-store model.
module tb_charlie_scan_ctrl;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        skip_off = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = 3'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        swap_req = 1'b0;
    logic        swap_pending, swap_done, frame_done;
    logic [5:0]  charlie_index;
    logic [63:0] frame_out;

    charlie_scan_ctrl #(.DWELL_CYCLES(DWELL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .skip_off      (skip_off),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .swap_req      (swap_req),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done),
        .frame_done    (frame_done),
        .charlie_index (charlie_index),
        .frame_out     (frame_out)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    bit [63:0] m_front, m_back, m_fout;
    bit        m_pend, m_scan, m_sdone, m_fdone;
    int        m_idx, m_cnt;

    typedef struct {
        bit en;
        bit sk;
        int exp_idx;
        bit exp_fdone;
    } vec_t;

    vec_t      vecs[36];
    int        seq[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
    int        cycles;
    bit        seen;
    logic [5:0] prev_idx;
    bit        r_en, r_sk, r_we, r_sr;
    bit [7:0]  r_data;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bit elig(input bit [63:0] b, input bit sk, input int i);
        return (i / 8 != i % 8) && (!sk || b[i]);
    endfunction

    function automatic int first_elig(input bit [63:0] b, input bit sk);
        for (int i = 0; i < 64; i++) if (elig(b, sk, i)) return i;
        return -1;
    endfunction

    function automatic int next_elig(input bit [63:0] b, input bit sk, input int cur);
        for (int k = 1; k <= 64; k++) begin
            int j = (cur + k) % 64;
            if (elig(b, sk, j)) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_front = '0; m_back = '0; m_fout = '0;
        m_pend = 0; m_scan = 0; m_sdone = 0; m_fdone = 0;
        m_idx = 0; m_cnt = 0;
    endfunction

    // One clock edge of the display controller as described behaviourally.
    function automatic void model_step();
        bit [63:0] nf, nb, no, src;
        bit np, ns, sd, fd, do_swap;
        int ni, nc, n;
        nf = m_front; nb = m_back; no = m_fout; np = m_pend; ns = m_scan;
        ni = m_idx; nc = m_cnt; sd = 0; fd = 0; do_swap = 0;
        if (wr_en) nb[int'(wr_row) * 8 +: 8] = wr_data;
        if (swap_req) np = 1;
        if (!m_scan) begin
            ni = 0; nc = 0; no = '0;
            do_swap = m_pend;
            if (enable) begin
                src = do_swap ? m_back : m_front;
                n = first_elig(src, skip_off);
                ns = 1;
                ni = (n < 0) ? 0 : n;
                no = (n < 0) ? 64'd0 : src;
            end
        end else if (!enable) begin
            ns = 0; ni = 0; nc = 0; no = '0;
        end else begin
            src = m_front;
            if (m_cnt == DWELL - 1) begin
                nc = 0;
                n = next_elig(m_front, skip_off, m_idx);
                if (n < 0 || n <= m_idx) begin
                    fd = 1;
                    if (m_pend) begin
                        do_swap = 1;
                        src = m_back;
                        n = first_elig(m_back, skip_off);
                    end
                end
                ni = (n < 0) ? 0 : n;
            end else begin
                nc = m_cnt + 1;
            end
            no = (first_elig(src, skip_off) < 0) ? 64'd0 : src;
        end
        if (do_swap) begin
            nf = m_back; np = 0; sd = 1;
        end
        m_front = nf; m_back = nb; m_fout = no; m_pend = np; m_scan = ns;
        m_idx = ni; m_cnt = nc; m_sdone = sd; m_fdone = fd;
    endfunction

    task automatic checkOutput();
        check("charlie_index", 64'(charlie_index), 64'(m_idx));
        check("frame_out", frame_out, m_fout);
        check("swap_pending", 64'(swap_pending), 64'(m_pend));
        check("swap_done", 64'(swap_done), 64'(m_sdone));
        check("frame_done", 64'(frame_done), 64'(m_fdone));
    endtask

    task automatic applyStimulus(input bit en, input bit sk, input bit we,
                                 input bit [2:0] row, input bit [7:0] data, input bit sr);
        enable = en; skip_off = sk; wr_en = we; wr_row = row; wr_data = data; swap_req = sr;
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    task automatic run_until(input bit want_swap, input int bound, output int n, output bit hit);
        n = 0; hit = 0;
        for (int c = 0; c < bound; c++) begin
            applyStimulus(enable, skip_off, 1'b0, 3'd0, 8'd0, 1'b0);
            n++;
            if (want_swap ? swap_done : frame_done) begin
                hit = 1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_index"}, 64'(charlie_index), 64'd0);
        check({tag, "_frame_out"}, frame_out, 64'd0);
        check({tag, "_pending"}, 64'(swap_pending), 64'd0);
        check({tag, "_swap_done"}, 64'(swap_done), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 36; k++) begin
            vecs[k].en = 1;
            vecs[k].sk = 0;
            vecs[k].exp_idx = seq[k / 4];
            vecs[k].exp_fdone = 0;
        end
        model_reset();

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Scan start: each index held for exactly DWELL cycles, diagonal 9 skipped.
        for (int k = 0; k < 36; k++) begin
            applyStimulus(vecs[k].en, vecs[k].sk, 1'b0, 3'd0, 8'd0, 1'b0);
            check("table_index", 64'(charlie_index), 64'(vecs[k].exp_idx));
            check("table_frame_done", 64'(frame_done), 64'(vecs[k].exp_fdone));
        end

        // Full frame: wrap 62 -> 1, period 56 * DWELL.
        seen = 0;
        prev_idx = '0;
        for (int c = 0; c < 400; c++) begin
            prev_idx = charlie_index;
            applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        check("frame_boundary_seen", 64'(seen), 64'd1);
        check("index_before_wrap", 64'(prev_idx), 64'd62);
        check("index_after_wrap", 64'(charlie_index), 64'd1);
        run_until(1'b0, 400, cycles, seen);
        check("frame_period_seen", 64'(seen), 64'd1);
        check("frame_period", 64'(cycles), 64'd224);

        // Row write plus mid-frame swap request: nothing visible until the boundary.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        check("swap_pending_set", 64'(swap_pending), 64'd1);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
            if (frame_done) begin
                seen = 1;
                check("swap_row3", 64'(frame_out[31:24]), 64'hA5);
                check("swap_frame_out", frame_out, 64'h0000_0000_A500_0000);
                check("swap_done_with_boundary", 64'(swap_done), 64'd1);
                check("swap_pending_cleared", 64'(swap_pending), 64'd0);
                break;
            end
            check("pending_hold", 64'(swap_pending), 64'd1);
            check("frame_out_hold", frame_out, 64'd0);
        end
        check("swap_boundary_seen", 64'(seen), 64'd1);

        // Only LEDs 5 and 40 lit, skip_off: index alternates with an 8-cycle frame.
        for (int r = 0; r < 8; r++) begin
            r_data = (r == 0) ? 8'h20 : (r == 5) ? 8'h01 : 8'h00;
            applyStimulus(1'b1, 1'b0, 1'b1, 3'(r), r_data, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        run_until(1'b1, 300, cycles, seen);
        check("sparse_swap_seen", 64'(seen), 64'd1);
        check("sparse_frame_out", frame_out, 64'h0000_0100_0000_0020);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        run_until(1'b0, 20, cycles, seen);
        check("sparse_boundary_seen", 64'(seen), 64'd1);
        check("sparse_index_5", 64'(charlie_index), 64'd5);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        check("sparse_index_40", 64'(charlie_index), 64'd40);
        check("sparse_no_boundary", 64'(frame_done), 64'd0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        check("sparse_period_8", 64'(frame_done), 64'd1);
        check("sparse_index_back_5", 64'(charlie_index), 64'd5);

        // Empty front with skip_off: blank output, boundary every DWELL cycles.
        for (int r = 0; r < 8; r++) applyStimulus(1'b1, 1'b1, 1'b1, 3'(r), 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        run_until(1'b1, 20, cycles, seen);
        check("empty_swap_seen", 64'(seen), 64'd1);
        check("empty_index", 64'(charlie_index), 64'd0);
        check("empty_frame_out", frame_out, 64'd0);
        run_until(1'b0, 10, cycles, seen);
        check("empty_period_seen", 64'(seen), 64'd1);
        check("empty_period", 64'(cycles), 64'(DWELL));
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 8'h3C, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        run_until(1'b1, 10, cycles, seen);
        check("empty_exit_swap_seen", 64'(seen), 64'd1);
        check("empty_exit_frame_done", 64'(frame_done), 64'd1);
        check("empty_exit_index", 64'(charlie_index), 64'd19);
        check("empty_exit_frame_out", frame_out, 64'h0000_0000_003C_0000);

        // Enable drop with a swap pending: blank first, swap lands one edge later.
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 8'h77, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        check("drop_pending_set", 64'(swap_pending), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        check("drop_index", 64'(charlie_index), 64'd0);
        check("drop_frame_out", frame_out, 64'd0);
        check("drop_no_swap_yet", 64'(swap_done), 64'd0);
        check("drop_pending_kept", 64'(swap_pending), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        check("idle_swap_done", 64'(swap_done), 64'd1);
        check("idle_pending_clear", 64'(swap_pending), 64'd0);
        check("idle_no_frame_done", 64'(frame_done), 64'd0);

        // Asynchronous reset mid-dwell clears outputs without a clock edge.
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        r_sk = 0;
        for (int c = 0; c < 3000; c++) begin
            r_en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 39) == 0) r_sk = ~r_sk;
            r_we = ($urandom_range(0, 2) == 0);
            r_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            r_sr = ($urandom_range(0, 11) == 0);
            applyStimulus(r_en, r_sk, r_we, 3'($urandom_range(0, 7)), r_data, r_sr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
